// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//
// Fetch stage and IF/ID pipeline register of a 5-stage RV32I core.
// It holds the PC register, selects the next fetch address (sequential,
// branch/jal target, or jalr target) and captures the fetched instruction
// into the decode-stage bundle. Stall and flush decisions come from the
// hazard controller and are applied here. A saturating counter records
// how many real instructions were squashed by flushes.
//
// Handshake: there is no valid/ready pair here. StallF/StallD act as an
// inverted "ready" from the downstream pipeline. When a stall is high the
// corresponding register holds. FlushD overrides StallD. ValidD marks
// whether the decode bundle carries a real instruction (1) or a bubble (0).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   StallF, StallD, FlushD hazard controls
//   PCSrcE                 00 seq, 01/11 PCTargetE, 10 ALUResultE (jalr)
//   PCTargetE, ALUResultE  redirect targets from execute
//   InstrF                 combinational instruction memory data for PCF
//   PCF                    fetch address
//   InstrD, PCD, PCPlus4D  decode-stage bundle
//   ValidD                 1 = real instruction, 0 = bubble
//   BubbleCnt              saturating count of squashed valid instructions
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [1:0]       PCSrcE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      ALUResultE,
    input  logic [31:0]      InstrF,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pcd_q, pcd_d;
    logic [31:0]      pcp4d_q, pcp4d_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next_f;
    logic        redirect;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4_f = pc_q + 32'd4;
    assign redirect   = (PCSrcE != 2'b00);

    always_comb begin
        pc_next_f = pc_plus4_f;
        case (PCSrcE)
            2'b00:   pc_next_f = pc_plus4_f;
            2'b10:   pc_next_f = {ALUResultE[31:1], 1'b0};
            default: pc_next_f = PCTargetE;   // 01 and 11
        endcase
    end

    // A redirect must never be lost, so it overrides StallF.
    always_comb begin
        pc_d = pc_next_f;
        if (StallF && !redirect) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4d_d = 32'd0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4d_d = pc_plus4_f;
            valid_d = 1'b1;
        end
    end

    // Only squashing a real instruction counts; re-flushing a bubble does not.
    always_comb begin
        cnt_d = cnt_q;
        if (FlushD && valid_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4d_q;
    assign ValidD    = valid_q;
    assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] IMASK  = 32'hA5A5_0000;
    localparam int          CW     = 2;
    localparam int          EXP_W  = 32 + 32 + 1 + CW;
    localparam int          NVEC   = 20;

    logic          clk;
    logic          rst_n;
    logic          StallF, StallD, FlushD;
    logic [1:0]    PCSrcE;
    logic [31:0]   PCTargetE, ALUResultE, InstrF;
    logic [31:0]   PCF, InstrD, PCD, PCPlus4D;
    logic          ValidD;
    logic [CW-1:0] BubbleCnt;

    int checks = 0;
    int errors = 0;

    fetch_decode_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .BubbleCnt  (BubbleCnt)
    );

    // Instruction memory model: content is a recognisable function of address.
    assign InstrF = PCF ^ IMASK;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sf, sd, fd;
        logic [1:0]  src;
        logic [31:0] tgt, alu;
        logic [31:0] e_pcf, e_pcd;
        logic        e_v;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[NVEC];
    logic [EXP_W-1:0] exp_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Checks the whole decode bundle; InstrD/PCPlus4D expectations follow from PCD/valid.
    task automatic check_all(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                             input logic e_v, input logic [CW-1:0] e_cnt);
        cmp({tag, ".PCF"},       PCF,              e_pcf);
        cmp({tag, ".PCD"},       PCD,              e_pcd);
        cmp({tag, ".ValidD"},    {31'd0, ValidD},  {31'd0, e_v});
        cmp({tag, ".InstrD"},    InstrD,           e_v ? (e_pcd ^ IMASK) : NOP);
        cmp({tag, ".PCPlus4D"},  PCPlus4D,         e_v ? (e_pcd + 32'd4) : 32'd0);
        cmp({tag, ".BubbleCnt"}, {30'd0, BubbleCnt}, {30'd0, e_cnt});
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic [1:0] src,
                         input logic [31:0] tgt, input logic [31:0] alu);
        StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE = src; PCTargetE = tgt; ALUResultE = alu;
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        string tag;

        //             sf    sd    fd    src    tgt            alu            pcf            pcd            v     cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h104,       32'h100,       1'b1, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h108,       32'h104,       1'b1, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         32'h108,       32'h104,       1'b1, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h10C,       32'h108,       1'b1, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h200,       32'h0,         32'h200,       32'h0,         1'b0, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h204,       32'h200,       1'b1, 2'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h208,       32'h0,         1'b0, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         32'h20C,       32'h0,         1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h210,       32'h20C,       1'b1, 2'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0,         32'h301,       32'h300,       32'h0,         1'b0, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h304,       32'h300,       1'b1, 2'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h308,       32'h0,         1'b0, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h30C,       32'h308,       1'b1, 2'd3};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h310,       32'h0,         1'b0, 2'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h0,         1'b0, 2'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1, 2'd3};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h4,         32'h0,         1'b1, 2'd3};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 2'b11, 32'h400,       32'h500,       32'h400,       32'h0,         1'b0, 2'd3};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h404,       32'h400,       1'b1, 2'd3};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         32'h408,       32'h400,       1'b1, 2'd3};

        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst_n = 1'b0;
        #12;
        check_all("reset", RST_PC, 32'h0, 1'b0, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].src, vecs[i].tgt, vecs[i].alu);
            exp_q.push_back({vecs[i].e_pcf, vecs[i].e_pcd, vecs[i].e_v, vecs[i].e_cnt});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tag = $sformatf("vec%0d", i);
            check_all(tag, e[EXP_W-1 -: 32], e[CW+32 -: 32], e[CW], e[CW-1:0]);
        end

        // Reset asserted mid-cycle with a stall and a redirect pending.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h700, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", RST_PC, 32'h0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check_all("rst_hold", RST_PC, 32'h0, 1'b0, 2'd0);

        // Release: first edge captures RESET_PC into decode.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", RST_PC + 32'd4, RST_PC, 1'b1, 2'd0);

        cmp("exp_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
